// File: rtl/ucie_ctl_sb_packet_framer_if.sv
// Sideband message request and packet-beat stream between a controller and the framer.
interface ucie_ctl_sb_packet_framer_if;
  logic        i_start;
  logic [4:0]  i_opcode;
  logic [7:0]  i_msgcode;
  logic [7:0]  i_subcode;
  logic [15:0] i_msginfo;
  logic [63:0] i_data;
  logic [1:0]  i_sel_data;
  logic        i_ignore_data2;
  logic [31:0] o_pkt_beat;
  logic        o_pkt_valid;
  logic        i_pkt_ready;
  logic        o_busy;
  logic        o_done;
  logic        o_overrun;

  modport master (
    output i_start, i_opcode, i_msgcode, i_subcode, i_msginfo, i_data,
           i_sel_data, i_ignore_data2, i_pkt_ready,
    input  o_pkt_beat, o_pkt_valid, o_busy, o_done, o_overrun
  );

  modport slave (
    input  i_start, i_opcode, i_msgcode, i_subcode, i_msginfo, i_data,
           i_sel_data, i_ignore_data2, i_pkt_ready,
    output o_pkt_beat, o_pkt_valid, o_busy, o_done, o_overrun
  );
endinterface

// File: rtl/ucie_ctl_sb_packet_framer.sv
// Frames a sideband message into 2-4 beats (two headers plus optional payload dwords)
// with control/data parity, valid/ready backpressure, done pulse and sticky overrun.
module ucie_ctl_sb_packet_framer #(
  parameter int unsigned BEAT_W = 32
) (
  input logic                     i_clk,
  input logic                     i_rst,
  ucie_ctl_sb_packet_framer_if.slave sb
);

  typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA0, DATA1} state_t;

  state_t state, state_nxt;

  logic [BEAT_W-1:0] hdr0_in, hdr1_in, d0_in, d1_in;
  logic              has_d0_in, has_d1_in, dp_in, cp_in;

  logic [BEAT_W-1:0] hdr1_q, d0_q, d1_q;
  logic              has_d0_q, has_d1_q;

  logic [BEAT_W-1:0] beat_q, beat_nxt;
  logic              valid_q, valid_nxt;
  logic              busy_q, busy_nxt;
  logic              done_q, done_nxt;
  logic              overrun_q, overrun_nxt;

  logic start_ok, accept;

  // A start in the done cycle is still a collision even though the FSM is already IDLE.
  assign start_ok = sb.i_start && (state == IDLE) && !done_q;
  assign accept   = valid_q && sb.i_pkt_ready;

  // Build the whole packet from the live inputs so HDR0 can be presented one cycle after start.
  always_comb begin
    has_d0_in = (sb.i_sel_data == 2'b01) || (sb.i_sel_data == 2'b10);
    has_d1_in = (sb.i_sel_data == 2'b01);
    d0_in     = sb.i_data[31:0];
    d1_in     = sb.i_ignore_data2 ? 32'h0 : sb.i_data[63:32];
    dp_in     = (has_d0_in & (^d0_in)) ^ (has_d1_in & (^d1_in));
    hdr0_in   = {sb.i_msginfo, sb.i_msgcode, 3'b000, sb.i_opcode};
    cp_in     = (^hdr0_in) ^ (^sb.i_subcode);
    hdr1_in   = {dp_in, cp_in, 22'h0, sb.i_subcode};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start_ok) state_nxt = HDR0;
      HDR0:    if (accept)   state_nxt = HDR1;
      HDR1:    if (accept)   state_nxt = has_d0_q ? DATA0 : IDLE;
      DATA0:   if (accept)   state_nxt = has_d1_q ? DATA1 : IDLE;
      DATA1:   if (accept)   state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  // Outputs are registered, so they are computed from the state being entered.
  always_comb begin
    beat_nxt    = beat_q;
    valid_nxt   = (state_nxt != IDLE);
    done_nxt    = accept && (state_nxt == IDLE);
    busy_nxt    = (state_nxt != IDLE) || done_nxt;
    overrun_nxt = overrun_q || (sb.i_start && !((state == IDLE) && !done_q));
    if (start_ok) begin
      beat_nxt = hdr0_in;
    end else if (accept) begin
      unique case (state_nxt)
        HDR1:    beat_nxt = hdr1_q;
        DATA0:   beat_nxt = d0_q;
        DATA1:   beat_nxt = d1_q;
        default: beat_nxt = '0;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      beat_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      hdr1_q    <= '0;
      d0_q      <= '0;
      d1_q      <= '0;
      has_d0_q  <= 1'b0;
      has_d1_q  <= 1'b0;
    end else begin
      beat_q    <= beat_nxt;
      valid_q   <= valid_nxt;
      busy_q    <= busy_nxt;
      done_q    <= done_nxt;
      overrun_q <= overrun_nxt;
      if (start_ok) begin
        hdr1_q   <= hdr1_in;
        d0_q     <= d0_in;
        d1_q     <= d1_in;
        has_d0_q <= has_d0_in;
        has_d1_q <= has_d1_in;
      end
    end
  end

  assign sb.o_pkt_beat  = beat_q;
  assign sb.o_pkt_valid = valid_q;
  assign sb.o_busy      = busy_q;
  assign sb.o_done      = done_q;
  assign sb.o_overrun   = overrun_q;

endmodule

// File: doc/ucie_ctl_sb_packet_framer.md
UCIE_CTL_SB_PACKET_FRAMER -- requirements
Module: ucie_ctl_sb_packet_framer

Interface
REQ-001 SHALL have parameter BEAT_W, default 32, meaning output beat width; only 32 is supported.
REQ-002 SHALL have port i_clk  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port i_start  input  1  one-cycle pulse: message fields below are valid this cycle.
REQ-005 SHALL have port i_opcode  input  5  sideband opcode read from regfile.
REQ-006 SHALL have port i_msgcode  input  8  message code.
REQ-007 SHALL have port i_subcode  input  8  message subcode.
REQ-008 SHALL have port i_msginfo  input  16  message info field.
REQ-009 SHALL have port i_data  input  64  payload.
REQ-010 SHALL have port i_sel_data  input  2  payload select: 00 none, 01 64-bit, 10 32-bit, 11 reserved.
REQ-011 SHALL have port i_ignore_data2  input  1  with sel 01: upper dword forced to zero.
REQ-012 SHALL have port o_pkt_beat  output  32  current packet beat.
REQ-013 SHALL have port o_pkt_valid  output  1  beat valid.
REQ-014 SHALL have port i_pkt_ready  input  1  downstream accepts beat.
REQ-015 SHALL have port o_busy  output  1  packet in progress.
REQ-016 SHALL have port o_done  output  1  one-cycle pulse, last beat accepted.
REQ-017 SHALL have port o_overrun  output  1  sticky: i_start received while busy.

Function
REQ-018 SHALL implement FSM IDLE, HDR0, HDR1, DATA0, DATA1.
REQ-019 SHALL, in IDLE on i_start, register all fields and move to HDR0; o_pkt_valid rises the next cycle (latency 1).
REQ-020 SHALL drive beat HDR0 = {msginfo[15:0], msgcode[7:0], 3'b000, opcode[4:0]}.
REQ-021 SHALL drive beat HDR1 = {dp, cp, 22'h0, subcode[7:0]}; cp = XOR of all HDR0 bits and HDR1[29:0]; dp = XOR of all transmitted payload bits.
REQ-022 SHALL send DATA0 = data[31:0] for sel 01/10, and DATA1 = data[63:32] (or 0 if i_ignore_data2) for sel 01 only.
REQ-023 SHALL treat sel 11 as sel 00, and sel 00 as a two-beat packet with dp = 0.
REQ-024 SHALL hold o_pkt_beat stable and o_pkt_valid high until i_pkt_ready; a state advances only on valid && ready.
REQ-025 SHALL, on acceptance of the final beat, return to IDLE, drop o_pkt_valid, and pulse o_done in the following cycle.
REQ-026 SHALL keep o_busy high from the cycle after i_start until o_done, inclusive.
REQ-027 SHALL ignore i_start while not IDLE (including the o_done cycle) and set o_overrun, cleared only by reset.
REQ-028 SHALL accept a new i_start in the cycle after o_done; minimum packet spacing is beats+2 cycles.

Reset
REQ-029 SHALL, on i_rst high, immediately set FSM to IDLE and all outputs to 0 (o_pkt_beat 32'h0); any packet in flight is abandoned.
REQ-030 SHALL ignore i_start while i_rst is high; operation resumes on the first edge after release.

Verification
REQ-031 SHALL cover a no-data packet: opcode 5'b10010, msgcode 8'h01, subcode 8'h01, msginfo 0, sel 00, ready=1 -> beats 32'h0000_0112, 32'h0000_0001, then o_done pulse.
REQ-032 SHALL cover a 64-bit packet: opcode 5'b11011, msgcode 8'h01, subcode 0, msginfo 0, data 64'h3, sel 01, ignore 0 -> beats 32'h0000_011B, 32'h4000_0000, 32'h0000_0003, 32'h0000_0000.
REQ-033 SHALL cover ignore_data2: data 64'hFFFF_FFFF_0000_0001, sel 01, ignore 1 -> DATA1 = 0, dp = 1.
REQ-034 SHALL cover backpressure: ready low 3 cycles during HDR1 -> beat and valid held unchanged, no skipped or duplicated beats.
REQ-035 SHALL cover overrun: i_start during DATA0 -> packet unaffected, o_overrun = 1 until reset.
REQ-036 SHALL cover mid-packet reset: i_rst asserted in HDR1 -> outputs 0 the same cycle; next i_start yields a complete fresh packet.
